// File: rtl/raster_stamp_rx_pkg.sv
// Shared types for the raster stamp receiver: stamp layout, fetch FSM encoding
// and the lane-valid rule.
package VX_raster_pkg;

    localparam int RASTER_POS_W  = 8;
    localparam int RASTER_MASK_W = 4;
    localparam int RASTER_PID_W  = 6;

    typedef struct packed {
        logic [RASTER_POS_W-1:0]  pos_x;
        logic [RASTER_POS_W-1:0]  pos_y;
        logic [RASTER_MASK_W-1:0] mask;
        logic [RASTER_PID_W-1:0]  pid;
    } raster_stamp_t;

    localparam int RASTER_RX_STATE_W = 2;

    typedef enum logic [RASTER_RX_STATE_W-1:0] {
        RX_IDLE = 2'd0,
        RX_WAIT = 2'd1,
        RX_RESP = 2'd2
    } raster_rx_state_e;

    // A lane carries work only if at least one pixel of its stamp is covered.
    function automatic logic lane_active(input raster_stamp_t s);
        return s.mask != '0;
    endfunction

endpackage

// File: rtl/raster_stamp_fifo.sv
// Circular bundle buffer with synchronous flush; write data is visible the
// cycle after the push (no fall-through path).
module raster_stamp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/raster_stamp_rx.sv
// Core-side raster receiver: buffers stamp bundles and answers one outstanding
// warp fetch at a time. Define RASTER_RX_PERF_EN to add the perf counter ports.
module raster_stamp_rx
    import VX_raster_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            in_valid,
    input  raster_stamp_t [NUM_LANES-1:0]   in_stamps,
    input  logic                            in_done,
    output logic                            in_ready,
    input  logic                            fetch_valid,
    input  logic [TAG_WIDTH-1:0]            fetch_tag,
    output logic                            fetch_ready,
    output logic                            rsp_valid,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    output raster_stamp_t [NUM_LANES-1:0]   rsp_stamps,
    output logic [NUM_LANES-1:0]            rsp_mask,
    output logic                            rsp_done,
    input  logic                            rsp_ready,
    output logic                            busy
`ifdef RASTER_RX_PERF_EN
    ,
    output logic [43:0]                     perf_stamps_out,
    output logic [43:0]                     perf_stall_out
`endif
);
    localparam int BW = NUM_LANES * $bits(raster_stamp_t);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    raster_rx_state_e              state_q, state_d;
    logic [TAG_WIDTH-1:0]          tag_q, tag_d;
    raster_stamp_t [NUM_LANES-1:0] stamps_q, stamps_d, head;
    logic [NUM_LANES-1:0]          mask_q, mask_d, head_mask;
    logic                          done_q, done_d;
    logic                          done_seen_q, done_seen_d;
    logic                          init_q;
    logic                          fifo_full, fifo_empty, push, pop, in_accept, take;
    logic [CW-1:0]                 fifo_count;

    raster_stamp_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (clear),
        .push_i  (push),
        .data_i  (in_stamps),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign head_mask[l] = lane_active(head[l]);
    end

    // clear wins over a same-cycle beat even though in_ready may read high.
    assign in_ready    = init_q && !fifo_full && !done_seen_q;
    assign in_accept   = in_valid && in_ready && !clear;
    assign push        = in_accept && !in_done;
    assign done_seen_d = clear ? 1'b0 : (done_seen_q || (in_accept && in_done));

    assign fetch_ready = (state_q == RX_IDLE);
    assign rsp_valid   = (state_q == RX_RESP);
    assign rsp_tag     = tag_q;
    assign rsp_stamps  = stamps_q;
    assign rsp_mask    = mask_q;
    assign rsp_done    = done_q;
    assign busy        = (fifo_count != '0) || (state_q != RX_IDLE);
    assign take        = (state_q == RX_WAIT) || (state_q == RX_IDLE && fetch_valid);

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        stamps_d = stamps_q;
        mask_d   = mask_q;
        done_d   = done_q;
        pop      = 1'b0;
        if (state_q == RX_IDLE && fetch_valid) tag_d = fetch_tag;
        if (state_q == RX_RESP) begin
            if (rsp_ready) state_d = RX_IDLE;
        end else if (take) begin
            // A flushing cycle sees neither data nor done: the fetch waits.
            if (!clear && !fifo_empty) begin
                pop      = 1'b1;
                stamps_d = head;
                mask_d   = head_mask;
                done_d   = 1'b0;
                state_d  = RX_RESP;
            end else if (!clear && done_seen_q) begin
                stamps_d = '0;
                mask_d   = '0;
                done_d   = 1'b1;
                state_d  = RX_RESP;
            end else begin
                state_d  = RX_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RX_IDLE;
            tag_q       <= '0;
            stamps_q    <= '0;
            mask_q      <= '0;
            done_q      <= 1'b0;
            done_seen_q <= 1'b0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            stamps_q    <= stamps_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
            done_seen_q <= done_seen_d;
            init_q      <= 1'b1;
        end
    end

`ifdef RASTER_RX_PERF_EN
    logic [43:0] perf_stamps_q, perf_stall_q, lanes_out;

    always_comb begin
        lanes_out = '0;
        for (int i = 0; i < NUM_LANES; i++) lanes_out = lanes_out + 44'(mask_q[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stamps_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (rsp_valid && rsp_ready) perf_stamps_q <= perf_stamps_q + lanes_out;
            if (state_q == RX_WAIT)     perf_stall_q  <= perf_stall_q + 44'd1;
        end
    end

    assign perf_stamps_out = perf_stamps_q;
    assign perf_stall_out  = perf_stall_q;
`endif

endmodule

// File: tb/tb_raster_stamp_rx.sv
// Scoreboard bench for raster_stamp_rx: bundles are queued as they are pushed
// and checked against the responses in fetch order.
module tb_raster_stamp_rx;
    import VX_raster_pkg::*;

    localparam int NL = 4;
    localparam int TW = 4;

    typedef raster_stamp_t [NL-1:0] bundle_t;
    typedef struct packed {
        logic [TW-1:0] tag;
        bundle_t       stamps;
        logic [NL-1:0] mask;
        logic          done;
    } rsp_t;

    logic          clk, reset_n, clear, in_valid, in_done, in_ready;
    bundle_t       in_stamps, rsp_stamps;
    logic          fetch_valid, fetch_ready, rsp_valid, rsp_done, rsp_ready, busy;
    logic [TW-1:0] fetch_tag, rsp_tag;
    logic [NL-1:0] rsp_mask;
`ifdef RASTER_RX_PERF_EN
    logic [43:0]   perf_stamps_out, perf_stall_out;
`endif

    int total = 0;
    int bad   = 0;
    bundle_t sb[$];

    raster_stamp_rx #(.NUM_LANES(NL), .FIFO_DEPTH(8), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_stamps(in_stamps), .in_done(in_done), .in_ready(in_ready),
        .fetch_valid(fetch_valid), .fetch_tag(fetch_tag), .fetch_ready(fetch_ready),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_stamps(rsp_stamps),
        .rsp_mask(rsp_mask), .rsp_done(rsp_done), .rsp_ready(rsp_ready), .busy(busy)
`ifdef RASTER_RX_PERF_EN
        , .perf_stamps_out(perf_stamps_out), .perf_stall_out(perf_stall_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bundle_t mk_bundle(input logic [3:0] m0);
        bundle_t b;
        for (int i = 0; i < NL; i++) begin
            b[i].pos_x = 8'($urandom);
            b[i].pos_y = 8'($urandom);
            b[i].mask  = 4'($urandom_range(0, 15));
            b[i].pid   = 6'($urandom);
        end
        b[0].mask = m0;
        return b;
    endfunction

    function automatic logic [NL-1:0] exp_mask(input bundle_t b);
        logic [NL-1:0] m;
        for (int i = 0; i < NL; i++) m[i] = (b[i].mask != 4'd0);
        return m;
    endfunction

    function automatic bundle_t sb_pop();
        bundle_t b;
        b = 'x;
        if (sb.size() != 0) b = sb.pop_front();
        return b;
    endfunction

    task automatic push_bundle(input bundle_t b);
        int n = 0;
        in_valid = 1'b1; in_stamps = b; in_done = 1'b0;
        while (!in_ready && n < 50) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        sb.push_back(b);
    endtask

    // Issues one fetch and returns what came back; lat=1 means response the cycle after acceptance.
    task automatic fetch_get(input logic [TW-1:0] tag, output rsp_t got, output int lat);
        int n = 0;
        fetch_valid = 1'b1; fetch_tag = tag;
        while (!fetch_ready && n < 50) begin tick(); n++; end
        tick();
        fetch_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin tick(); lat++; end
        if (n >= 50) lat = 99;
        got.tag = rsp_tag; got.stamps = rsp_stamps; got.mask = rsp_mask; got.done = rsp_done;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        total++;
        if (in_ready !== 1'b0 || fetch_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_done !== 1'b0 || rsp_mask !== '0 || rsp_tag !== '0 || rsp_stamps !== '0) begin
            bad++;
            $display("FAIL reset_vals: in_ready=%b fetch_ready=%b rsp_valid=%b busy=%b done=%b mask=%b tag=%h, want 0 1 0 0 0 0 0",
                     in_ready, fetch_ready, rsp_valid, busy, rsp_done, rsp_mask, rsp_tag);
        end
        tick();
        reset_n = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_cycle_in_ready: got %b want 0", in_ready); end
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_order();
        logic [3:0] m0 [3] = '{4'd1, 4'd3, 4'd0};
        logic       l0 [3] = '{1'b1, 1'b1, 1'b0};
        rsp_t got; bundle_t exp; int lat;
        for (int i = 0; i < 3; i++) push_bundle(mk_bundle(m0[i]));
        for (int i = 0; i < 3; i++) begin
            fetch_get(TW'(i + 1), got, lat);
            exp = sb_pop();
            total++;
            if (got.tag !== TW'(i + 1) || got.stamps !== exp || got.mask !== exp_mask(exp) ||
                got.done !== 1'b0 || got.mask[0] !== l0[i] || lat != 1) begin
                bad++;
                $display("FAIL order[%0d]: got tag=%h mask=%b done=%b lat=%0d stamps=%h, want tag=%h mask=%b done=0 lat=1 stamps=%h",
                         i, got.tag, got.mask, got.done, lat, got.stamps, TW'(i + 1), exp_mask(exp), exp);
            end
        end
    endtask

    task automatic test_full();
        rsp_t got; bundle_t exp; int lat;
        for (int i = 0; i < 8; i++) push_bundle(mk_bundle(4'($urandom_range(0, 15))));
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        // Beat offered while full and popping: must not be taken.
        in_valid = 1'b1; in_stamps = mk_bundle(4'hf); in_done = 1'b0;
        fetch_valid = 1'b1; fetch_tag = 4'd9;
        tick();
        in_valid = 1'b0; fetch_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL pop_frees_slot: in_ready got %b want 1", in_ready); end
        exp = sb_pop();
        total++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd9 || rsp_stamps !== exp || rsp_mask !== exp_mask(exp)) begin
            bad++;
            $display("FAIL full_first_rsp: valid=%b tag=%h stamps=%h, want 1 9 %h", rsp_valid, rsp_tag, rsp_stamps, exp);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            fetch_get(TW'(i), got, lat);
            exp = sb_pop();
            total++;
            if (got.stamps !== exp || got.mask !== exp_mask(exp) || got.tag !== TW'(i) || got.done !== 1'b0 || lat != 1) begin
                bad++;
                $display("FAIL full_drain[%0d]: got stamps=%h mask=%b tag=%h lat=%0d, want stamps=%h mask=%b tag=%h lat=1",
                         i, got.stamps, got.mask, got.tag, lat, exp, exp_mask(exp), TW'(i));
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL full_drained_busy: got %b want 0 (no 9th bundle)", busy); end
    endtask

    task automatic test_wait();
        bundle_t b, exp;
        fetch_valid = 1'b1; fetch_tag = 4'd5;
        tick();
        fetch_valid = 1'b0;
        total++;
        if (fetch_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wait_state: fetch_ready=%b rsp_valid=%b busy=%b, want 0 0 1", fetch_ready, rsp_valid, busy);
        end
        b = mk_bundle(4'd2);
        in_valid = 1'b1; in_stamps = b; in_done = 1'b0;
        tick();
        in_valid = 1'b0;
        sb.push_back(b);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wait_n1: rsp_valid got %b want 0", rsp_valid); end
        tick();
        exp = sb_pop();
        total++;
        if (rsp_valid !== 1'b1 || rsp_stamps !== exp || rsp_tag !== 4'd5 || rsp_mask !== exp_mask(exp)) begin
            bad++;
            $display("FAIL wait_n2: valid=%b tag=%h stamps=%h, want 1 5 %h", rsp_valid, rsp_tag, rsp_stamps, exp);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_done();
        rsp_t got; bundle_t exp; int lat; int n = 0;
        push_bundle(mk_bundle(4'd4));
        push_bundle(mk_bundle(4'd8));
        in_valid = 1'b1; in_done = 1'b1; in_stamps = mk_bundle(4'hf);
        while (!in_ready && n < 50) begin tick(); n++; end
        tick();
        in_valid = 1'b0; in_done = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL done_backpressure: in_ready got %b want 0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            fetch_get(TW'(10 + i), got, lat);
            exp = sb_pop();
            total++;
            if (got.done !== 1'b0 || got.stamps !== exp || got.mask !== exp_mask(exp) || lat != 1) begin
                bad++;
                $display("FAIL done_data[%0d]: got done=%b stamps=%h lat=%0d, want done=0 stamps=%h lat=1", i, got.done, got.stamps, lat, exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            fetch_get(TW'(12 + i), got, lat);
            total++;
            if (got.done !== 1'b1 || got.mask !== '0 || got.stamps !== '0 || got.tag !== TW'(12 + i) || lat != 1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL done_token[%0d]: got done=%b mask=%b tag=%h lat=%0d in_ready=%b, want 1 0 %h 1 0",
                         i, got.done, got.mask, got.tag, lat, in_ready, TW'(12 + i));
            end
        end
        // clear together with a beat: clear wins, beat dropped.
        clear = 1'b1; in_valid = 1'b1; in_stamps = mk_bundle(4'd1);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_flush: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
        fetch_valid = 1'b1; fetch_tag = 4'd6;
        tick();
        fetch_valid = 1'b0;
        tick();
        total++;
        if (rsp_valid !== 1'b0 || fetch_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_then_wait: rsp_valid=%b fetch_ready=%b, want 0 0", rsp_valid, fetch_ready);
        end
        push_bundle(mk_bundle(4'd7));
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        exp = sb_pop();
        total++;
        if (rsp_valid !== 1'b1 || rsp_stamps !== exp || rsp_tag !== 4'd6 || rsp_done !== 1'b0) begin
            bad++;
            $display("FAIL wait_release: valid=%b tag=%h done=%b stamps=%h, want 1 6 0 %h", rsp_valid, rsp_tag, rsp_done, rsp_stamps, exp);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_hold();
        bundle_t exp;
        push_bundle(mk_bundle(4'd5));
        fetch_valid = 1'b1; fetch_tag = 4'd7;
        tick();
        fetch_valid = 1'b0;
        exp = sb_pop();
        for (int c = 0; c < 10; c++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd7 || rsp_stamps !== exp || rsp_mask !== exp_mask(exp) || rsp_done !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: valid=%b tag=%h mask=%b done=%b stamps=%h, want 1 7 %b 0 %h",
                         c, rsp_valid, rsp_tag, rsp_mask, rsp_done, rsp_stamps, exp_mask(exp), exp);
            end
            if (c == 2) begin in_valid = 1'b1; in_stamps = mk_bundle(4'd3); in_done = 1'b0; end
            if (c == 5) clear = 1'b1;
            tick();
            in_valid = 1'b0; clear = 1'b0;
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: rsp_valid=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        push_bundle(mk_bundle(4'd9));
        push_bundle(mk_bundle(4'd2));
        fetch_valid = 1'b1; fetch_tag = 4'd3;
        tick();
        fetch_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_resp: rsp_valid got %b want 1", rsp_valid); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || fetch_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: rsp_valid=%b fetch_ready=%b busy=%b in_ready=%b, want 0 1 0 0",
                     rsp_valid, fetch_ready, busy, in_ready);
        end
        sb.delete();
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (fetch_ready !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: fetch_ready=%b in_ready=%b, want 1 1", fetch_ready, in_ready);
        end
        fetch_valid = 1'b1; fetch_tag = 4'd1;
        tick();
        fetch_valid = 1'b0;
        tick();
        total++;
        if (rsp_valid !== 1'b0 || fetch_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_emptied_fifo: rsp_valid=%b fetch_ready=%b, want 0 0", rsp_valid, fetch_ready);
        end
    endtask

    initial begin
        clear = 1'b0; in_valid = 1'b0; in_done = 1'b0; in_stamps = '0;
        fetch_valid = 1'b0; fetch_tag = '0; rsp_ready = 1'b0;
        test_reset();
        test_order();
        test_full();
        test_wait();
        test_done();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
